// File: rtl/sequential_divider_if.sv
// Start/done handshake bundle for the radix-2 restoring divider.
// The master issues operands and start; the slave returns results and status.
interface sequential_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             divByZero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  quotient,
        input  remainder,
        input  busy,
        input  done,
        input  divByZero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output quotient,
        output remainder,
        output busy,
        output done,
        output divByZero
    );
endinterface

// File: rtl/sequential_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, fixed latency of WIDTH
// edges after the accepting edge regardless of operand values (including /0).
module sequential_divider #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sequential_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } stateT;

    stateT            state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divisorReg;

    logic [WIDTH-1:0] quotientReg;
    logic [WIDTH-1:0] remainderReg;
    logic             busyReg;
    logic             doneReg;
    logic             divByZeroReg;

    // One iteration: shift {R,Q} left, trial-subtract the divisor from R.
    // The trial is one bit wider than the shifted remainder so its top bit
    // is a clean borrow flag.
    logic [WIDTH:0]   shiftedRem;
    logic [WIDTH+1:0] trial;
    logic             trialOk;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    logic             lastIter;

    always_comb begin
        shiftedRem = {remReg, quoReg[WIDTH-1]};
        trial      = {1'b0, shiftedRem} - {2'b00, divisorReg};
        trialOk    = ~trial[WIDTH+1];
        // A successful trial always leaves R below the divisor, so the low
        // WIDTH bits hold the whole value; on restore R never exceeds WIDTH bits.
        remNext    = trialOk ? trial[WIDTH-1:0] : shiftedRem[WIDTH-1:0];
        quoNext    = {quoReg[WIDTH-2:0], trialOk};
        lastIter   = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            remReg       <= '0;
            quoReg       <= '0;
            divisorReg   <= '0;
            quotientReg  <= '0;
            remainderReg <= '0;
            busyReg      <= 1'b0;
            doneReg      <= 1'b0;
            divByZeroReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    doneReg <= 1'b0;
                    if (bus.start) begin
                        remReg     <= '0;
                        quoReg     <= bus.dividend;
                        divisorReg <= bus.divisor;
                        count      <= '0;
                        busyReg    <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    remReg <= remNext;
                    quoReg <= quoNext;
                    count  <= count + 1'b1;
                    // start is deliberately not looked at here: requests made
                    // while busy are dropped, never queued.
                    if (lastIter) begin
                        quotientReg  <= quoNext;
                        remainderReg <= remNext;
                        divByZeroReg <= (divisorReg == '0);
                        doneReg      <= 1'b1;
                        busyReg      <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                    doneReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.quotient  = quotientReg;
    assign bus.remainder = remainderReg;
    assign bus.busy      = busyReg;
    assign bus.done      = doneReg;
    assign bus.divByZero = divByZeroReg;
endmodule
